reg_bank_p: RTL
===============

# reg_bank_p

Parametrised successor to the 8-bit, 16-entry `reg_file`. It generalises data width, depth and read-port count, and adds a hard-wired zero register and write-to-read bypass. It also adds a per-register pending scoreboard for multi-cycle results and a registered CPU output port. It sits between decode (read addresses, pending-set) and writeback (ALU/load result) in the microprocessor datapath.

## Interface
Parameters:
- DATA_W, 8, register data width
- ADDR_W, 4, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes and pending-sets
- OUT_REG, 15, index mirrored onto CPU_OUT
- BYPASS, 1, when 1 same-cycle writes are forwarded to read ports

Ports:
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- RA  in  NUM_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- RD  out  NUM_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W]
- RD_PEND  out  NUM_RD  port k's register awaits an outstanding result
- WA  in  ADDR_W  write address
- WD  in  DATA_W  write data (ALUResult)
- WE  in  1  write enable
- PA  in  ADDR_W  pending-set address
- PE  in  1  pending-set enable (multi-cycle op issued to PA)
- CPU_OUT  out  DATA_W  registered copy of register OUT_REG
- PEND_ANY  out  1  OR of all pending bits

## Operation
- Storage: 2**ADDR_W x DATA_W flops, plus one pending bit per entry.
- Write: on rising CLK with WE=1, reg[WA] <= WD and pend[WA] <= 0. Skipped when ZERO_REG=1 and WA=0.
- Pending set: on rising CLK with PE=1, pend[PA] <= 1. Ignored when ZERO_REG=1 and PA=0.
- Simultaneous WE and PE to the same address: data is written and pend ends at 1. The set wins because it represents a newer producer.
- Read (combinational), per port k:
  - if ZERO_REG=1 and RA=0: RD = 0, RD_PEND = 0
  - else if BYPASS=1, WE=1 and WA=RA: RD = WD, RD_PEND = 0
  - else: RD = reg[RA], RD_PEND = pend[RA]
  - Bypass never reflects a same-cycle PE, which is not visible on RD_PEND until the next cycle.
- CPU_OUT: on rising CLK with WE=1 and WA=OUT_REG, CPU_OUT <= WD. It always equals reg[OUT_REG] after the edge.
- PEND_ANY: combinational OR of the pend vector.
- All ports are independent; any number may address the same register.

## Timing
- Reset (RST_N=0, asynchronous, no clock needed): all registers, all pend bits and CPU_OUT go to 0, so PEND_ANY=0. RD follows the cleared contents combinationally.
- Release is synchronous to the next rising CLK edge. The first write takes effect on the first edge with RST_N=1.
- Write-to-read latency: 0 cycles with BYPASS=1; 1 cycle with BYPASS=0.
- Pending-set to RD_PEND latency: 1 cycle. Clear via write: 0 cycles with bypass, 1 without.
- Reset mid-operation: writes and pending-sets on the asserting edge are lost. No partial state is retained.
- Address wrap: none. Every ADDR_W value is a legal register.

## Structure
- Package reg_bank_pkg holds the default constants DATA_W_DEF, ADDR_W_DEF, NUM_RD_DEF and OUT_REG_DEF, plus function is_zero_reg(addr, zero_en). Both the top and the sub-module import it.
- Sub-module reg_bank_rd_port is instantiated NUM_RD times via generate. Inputs: one address, the storage array, the pend vector and the write bus. Outputs: that port's RD and RD_PEND.
- The top holds storage, pend, CPU_OUT and the write/pending-set logic.

## Test plan
- Reset with RA={2,1}: write 0x20 to r3, assert RST_N=0 mid-cycle -> RD, CPU_OUT and PEND_ANY are 0 immediately, with no clock edge needed.
- WE=1, WA=0, WD=0x20 (ZERO_REG=1) -> RA=0 reads 0x00. With ZERO_REG=0 the next cycle reads 0x20.
- WE=1, WA=9, WD=0x23 and RA0=9 the same cycle -> RD0=0x23 in that cycle with BYPASS=1. With BYPASS=0, RD0 keeps the old value until after the edge.
- PE=1, PA=7, then RA1=7 -> RD_PEND[1]=1 and PEND_ANY=1 next cycle. Then WE=1, WA=7, WD=0x49 -> RD_PEND[1]=0 and RD1=0x49 in the same cycle.
- WE=1 and PE=1 both to r5, WD=0x14 -> after the edge reg5=0x14 and pend[5]=1.
- WE=1, WA=15, WD=0x4B -> CPU_OUT=0x4B after the edge. A write to r12 leaves CPU_OUT unchanged.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - default constants and helpers shared by the register bank
package reg_bank_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int ADDR_W_DEF  = 4;
    localparam int NUM_RD_DEF  = 2;
    localparam int OUT_REG_DEF = 15;

    // Register 0 is hard-wired only when the zero-register option is enabled
    function automatic logic is_zero_reg(input logic [31:0] addr, input logic zero_en);
        return zero_en && (addr == 32'd0);
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// rtl/reg_bank_if.sv - read/write/pending bus between decode, writeback and the register bank
interface reg_bank_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic [NUM_RD-1:0]        rd_pend;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic                     we;
    logic [ADDR_W-1:0]        pa;
    logic                     pe;
    logic [DATA_W-1:0]        cpu_out;
    logic                     pend_any;

    modport master (
        output ra, wa, wd, we, pa, pe,
        input  rd, rd_pend, cpu_out, pend_any
    );

    modport slave (
        input  ra, wa, wd, we, pa, pe,
        output rd, rd_pend, cpu_out, pend_any
    );
endinterface

// File: rtl/reg_bank_rd_port.sv
// rtl/reg_bank_rd_port.sv - one combinational read port with zero-register and write bypass
module reg_bank_rd_port
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]             addr,
    input  logic [(2**ADDR_W)*DATA_W-1:0] regs_flat,
    input  logic [2**ADDR_W-1:0]          pend,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             wa,
    input  logic [DATA_W-1:0]             wd,
    output logic [DATA_W-1:0]             rd,
    output logic                          rd_pend
);

    // A same-cycle pending-set is deliberately not forwarded; only writes are
    always_comb begin
        rd      = regs_flat[int'(addr)*DATA_W +: DATA_W];
        rd_pend = pend[addr];
        if (is_zero_reg(32'(addr), ZERO_REG != 0)) begin
            rd      = '0;
            rd_pend = 1'b0;
        end else if ((BYPASS != 0) && we && (wa == addr)) begin
            rd      = wd;
            rd_pend = 1'b0;
        end
    end

endmodule

// File: rtl/reg_bank_p.sv
// rtl/reg_bank_p.sv - parametrised register bank with pending scoreboard and CPU output mirror
module reg_bank_p
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = 1,
    parameter int OUT_REG  = OUT_REG_DEF,
    parameter int BYPASS   = 1
) (
    input logic     clk,
    input logic     rst_n,
    reg_bank_if.slave bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]       regs [DEPTH];
    logic [DEPTH-1:0]        pend;
    logic [DATA_W-1:0]       cpu_out_q;
    logic [DEPTH*DATA_W-1:0] regs_flat;
    logic [NUM_RD*DATA_W-1:0] rd_w;
    logic [NUM_RD-1:0]       rd_pend_w;
    logic                    wr_ok;
    logic                    set_ok;

    assign wr_ok  = bus.we && !is_zero_reg(32'(bus.wa), ZERO_REG != 0);
    assign set_ok = bus.pe && !is_zero_reg(32'(bus.pa), ZERO_REG != 0);

    // The pending-set is applied after the write-clear so a newer producer wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pend      <= '0;
            cpu_out_q <= '0;
        end else begin
            if (wr_ok) begin
                regs[bus.wa] <= bus.wd;
                pend[bus.wa] <= 1'b0;
            end
            if (set_ok) pend[bus.pa] <= 1'b1;
            if (wr_ok && (bus.wa == ADDR_W'(OUT_REG))) cpu_out_q <= bus.wd;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign regs_flat[i*DATA_W +: DATA_W] = regs[i];
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        reg_bank_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_port (
            .addr     (bus.ra[k*ADDR_W +: ADDR_W]),
            .regs_flat(regs_flat),
            .pend     (pend),
            .we       (bus.we),
            .wa       (bus.wa),
            .wd       (bus.wd),
            .rd       (rd_w[k*DATA_W +: DATA_W]),
            .rd_pend  (rd_pend_w[k])
        );
    end

    assign bus.rd       = rd_w;
    assign bus.rd_pend  = rd_pend_w;
    assign bus.cpu_out  = cpu_out_q;
    assign bus.pend_any = |pend;

endmodule
